// File: rtl/spi_master_pkg.sv
// Shared types and sizing helpers for the PL-side SPI master.
package spi_master_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DIV_W_DEF  = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_NEXT,
    ST_HOLD,
    ST_GAP
  } state_t;

  // Width needed to hold the values 0..n (bit counter loads DATA_W).
  function automatic int bit_cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/spi_master_clkgen.sv
// SCK generator: half-period down-counter, rise/fall strobes and the SCK flop.
// Strobes are combinational and mark the clk edge on which SCK toggles.
module spi_master_clkgen
  import spi_master_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             rise_o,
  output logic             fall_o,
  output logic             sck_o
);

  logic [DIV_W:0] cnt;
  logic           sck_q;

  assign rise_o = en_i && (cnt == '0) && !sck_q;
  assign fall_o = en_i && (cnt == '0) &&  sck_q;
  assign sck_o  = sck_q;

  // Load restarts a word with SCK low; while enabled, toggle SCK every H cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      sck_q <= 1'b0;
    end else if (load_i) begin
      cnt   <= {1'b0, div_i};
      sck_q <= 1'b0;
    end else if (en_i) begin
      if (cnt == '0) begin
        cnt   <= {1'b0, div_i};
        sck_q <= ~sck_q;
      end else begin
        cnt <= cnt - (DIV_W+1)'(1);
      end
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master with word-level valid/ready interface and multi-word frames.
module spi_master_ctrl
  import spi_master_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DIV_W  = DIV_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIV_W-1:0]  clk_div_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  input  logic [DATA_W-1:0] tx_data_i,
  input  logic              tx_last_i,
  output logic              rx_valid_o,
  output logic [DATA_W-1:0] rx_data_o,
  output logic              busy_o,
  output logic              spi_sck_o,
  output logic              spi_cs_o,
  output logic              spi_mosi_o,
  input  logic              spi_miso_i
);

  localparam int BC_W = bit_cnt_w(DATA_W);

  state_t            state, state_d;
  logic              hs, rise, fall, last_fall, sck_en;
  logic [DIV_W-1:0]  div_q, div_sel;
  logic              last_q;
  logic [BC_W-1:0]   bit_cnt;
  logic [DIV_W:0]    gap_cnt;
  logic [DATA_W-1:0] tx_sr, rx_sr;
  logic              ready_q, cs_q, rx_valid_q;
  logic [DATA_W-1:0] rx_data_q;

  assign hs        = tx_valid_i & ready_q;
  assign sck_en    = (state == ST_SHIFT);
  // The divider is sampled only at a frame's first word; later words reuse it.
  assign div_sel   = (state == ST_IDLE) ? clk_div_i : div_q;
  assign last_fall = fall && (bit_cnt == BC_W'(1));

  assign tx_ready_o = ready_q;
  assign spi_cs_o   = cs_q;
  assign spi_mosi_o = tx_sr[DATA_W-1];
  assign rx_valid_o = rx_valid_q;
  assign rx_data_o  = rx_data_q;
  assign busy_o     = (state != ST_IDLE);

  spi_master_clkgen #(.DIV_W(DIV_W)) u_clkgen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (hs),
    .en_i   (sck_en),
    .div_i  (div_sel),
    .rise_o (rise),
    .fall_o (fall),
    .sck_o  (spi_sck_o)
  );

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (hs) state_d = ST_SHIFT;
      ST_SHIFT: if (last_fall) state_d = last_q ? ST_HOLD : ST_NEXT;
      ST_NEXT:  if (hs) state_d = ST_SHIFT;
      ST_HOLD:  if (gap_cnt == '0) state_d = ST_GAP;
      ST_GAP:   if (gap_cnt == '0) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // State register; ready and CS are registered from the next state so they are glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ready_q <= 1'b0;
      cs_q    <= 1'b1;
    end else begin
      state   <= state_d;
      ready_q <= (state_d == ST_IDLE) || (state_d == ST_NEXT);
      cs_q    <= (state_d == ST_IDLE) || (state_d == ST_GAP);
    end
  end

  // Word datapath: load on handshake, sample MISO on rise, advance MOSI on fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_sr      <= '0;
      rx_sr      <= '0;
      bit_cnt    <= '0;
      last_q     <= 1'b0;
      div_q      <= '0;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
    end else begin
      rx_valid_q <= 1'b0;
      if (hs) begin
        tx_sr   <= tx_data_i;
        last_q  <= tx_last_i;
        bit_cnt <= BC_W'(DATA_W);
        if (state == ST_IDLE) div_q <= clk_div_i;
      end
      if (rise) rx_sr <= {rx_sr[DATA_W-2:0], spi_miso_i};
      if (fall) begin
        bit_cnt <= bit_cnt - BC_W'(1);
        if (bit_cnt == BC_W'(1)) begin
          rx_valid_q <= 1'b1;
          rx_data_q  <= rx_sr;
        end else begin
          tx_sr <= {tx_sr[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  // Times the H-cycle CS hold after the last word and the H-cycle idle gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt <= '0;
    end else if ((state == ST_SHIFT && last_fall && last_q) ||
                 (state == ST_HOLD && gap_cnt == '0)) begin
      gap_cnt <= {1'b0, div_q};
    end else if (gap_cnt != '0) begin
      gap_cnt <= gap_cnt - (DIV_W+1)'(1);
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: timing, framing, stall, divider and reset cases.
module tb_spi_master_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  clk_div = 8'd1;
  logic        tx_valid = 1'b0;
  logic        tx_ready;
  logic [31:0] tx_data = '0;
  logic        tx_last = 1'b0;
  logic        rx_valid;
  logic [31:0] rx_data;
  logic        busy, sck, cs, mosi, miso;

  logic        miso_q = 1'b0;
  int          miso_mode = 0;
  logic [31:0] pat = '0;

  int          cyc = 0;
  int          errors = 0, checks = 0;
  int          n_rise, n_fall, n_rx, n_cs_rise, cs_rise, cs_fall, rdy_rise, rx_cyc;
  int          rise_cyc [0:127];
  logic [63:0] mosi_log;
  logic [31:0] rx_first;
  logic        sck_p = 1'b0, cs_p = 1'b1, rdy_p = 1'b0;
  int          t, t2, stall_bad;

  spi_master_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clk_div_i  (clk_div),
    .tx_valid_i (tx_valid),
    .tx_ready_o (tx_ready),
    .tx_data_i  (tx_data),
    .tx_last_i  (tx_last),
    .rx_valid_o (rx_valid),
    .rx_data_o  (rx_data),
    .busy_o     (busy),
    .spi_sck_o  (sck),
    .spi_cs_o   (cs),
    .spi_mosi_o (mosi),
    .spi_miso_i (miso)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) miso_q <= mosi;

  // MISO source: flopped loopback, direct loopback, or pattern advanced per SCK fall.
  always_comb begin
    miso = 1'b0;
    case (miso_mode)
      0:       miso = miso_q;
      1:       miso = mosi;
      default: miso = (n_fall < 32) ? pat[31 - n_fall] : 1'b0;
    endcase
  end

  // Event monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (sck && !sck_p) begin
      if (n_rise < 128) rise_cyc[n_rise] = cyc;
      n_rise++;
      mosi_log = {mosi_log[62:0], mosi};
    end
    if (!sck && sck_p) n_fall++;
    if (cs && !cs_p) begin n_cs_rise++; cs_rise = cyc; end
    if (!cs && cs_p) cs_fall = cyc;
    if (tx_ready && !rdy_p) rdy_rise = cyc;
    if (rx_valid) begin
      n_rx++;
      rx_cyc = cyc;
      if (n_rx == 1) rx_first = rx_data;
    end
    sck_p = sck; cs_p = cs; rdy_p = tx_ready;
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_mon;
    n_rise = 0; n_fall = 0; n_rx = 0; n_cs_rise = 0;
    cs_rise = -1; cs_fall = -1; rdy_rise = -1; rx_cyc = -1;
    mosi_log = '0; rx_first = '0;
    for (int i = 0; i < 128; i++) rise_cyc[i] = -1;
  endtask

  // Offer one word; returns the handshake cycle, leaving time in the cycle after it.
  task automatic xfer(input logic [31:0] d, input logic l, output int hs_cyc);
    tx_valid = 1'b1; tx_data = d; tx_last = l; hs_cyc = -1;
    for (int i = 0; i < 2000 && hs_cyc < 0; i++) begin
      if (tx_ready) hs_cyc = cyc;
      tick;
    end
    tx_valid = 1'b0;
    chk("handshake", 64'(hs_cyc >= 0), 64'(1));
  endtask

  task automatic wait_idle;
    for (int i = 0; i < 40000 && busy; i++) tick;
    chk("idle_timeout", 64'(busy), 64'(0));
    tick; tick;
  endtask

  initial begin
    clr_mon;
    repeat (3) tick;
    chk("rst_cs", 64'(cs), 64'(1));
    chk("rst_sck", 64'(sck), 64'(0));
    chk("rst_mosi", 64'(mosi), 64'(0));
    chk("rst_ready", 64'(tx_ready), 64'(0));
    chk("rst_rxv", 64'(rx_valid), 64'(0));
    chk("rst_rxd", 64'(rx_data), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    rst_n = 1'b1;
    tick; tick;
    chk("ready_idle", 64'(tx_ready), 64'(1));

    // Single word, H=2, flopped loopback.
    clk_div = 8'd1; miso_mode = 0; clr_mon;
    xfer(32'hA5A5_0F0F, 1'b1, t);
    chk("t1_cs_low", 64'(cs), 64'(0));
    chk("t1_mosi_msb", 64'(mosi), 64'(1));
    wait_idle;
    chk("t1_cs_fall", 64'(cs_fall), 64'(t + 1));
    chk("t1_rise0", 64'(rise_cyc[0]), 64'(t + 3));
    chk("t1_rise1", 64'(rise_cyc[1]), 64'(t + 7));
    chk("t1_nrise", 64'(n_rise), 64'(32));
    chk("t1_rx_cyc", 64'(rx_cyc), 64'(t + 129));
    chk("t1_rx_data", 64'(rx_first), 64'h0000_0000_A5A5_0F0F);
    chk("t1_rx_hold", 64'(rx_data), 64'h0000_0000_A5A5_0F0F);
    chk("t1_cs_rise", 64'(cs_rise), 64'(t + 131));
    chk("t1_rdy_rise", 64'(rdy_rise), 64'(t + 133));
    chk("t1_mosi", 64'(mosi_log[31:0]), 64'h0000_0000_A5A5_0F0F);

    // Two-word frame, valid held.
    clr_mon;
    xfer(32'h1234_5678, 1'b0, t);
    xfer(32'hDEAD_BEEF, 1'b1, t2);
    wait_idle;
    chk("t2_next_hs", 64'(t2), 64'(t + 129));
    chk("t2_cs_rises", 64'(n_cs_rise), 64'(1));
    chk("t2_nrise", 64'(n_rise), 64'(64));
    chk("t2_nrx", 64'(n_rx), 64'(2));
    chk("t2_mosi", mosi_log, {32'h1234_5678, 32'hDEAD_BEEF});
    chk("t2_rx0", 64'(rx_first), 64'h0000_0000_1234_5678);
    chk("t2_rx1", 64'(rx_data), 64'h0000_0000_DEAD_BEEF);

    // Stall in NEXT for 50 cycles.
    clr_mon;
    xfer(32'hCAFE_F00D, 1'b0, t);
    for (int i = 0; i < 2000 && !tx_ready; i++) tick;
    chk("t3_next_ready", 64'(tx_ready), 64'(1));
    stall_bad = 0;
    repeat (50) begin
      if (sck !== 1'b0 || cs !== 1'b0 || tx_ready !== 1'b1) stall_bad++;
      tick;
    end
    chk("t3_stall", 64'(stall_bad), 64'(0));
    chk("t3_nrise_stall", 64'(n_rise), 64'(32));
    chk("t3_rx0", 64'(rx_first), 64'h0000_0000_CAFE_F00D);
    xfer(32'h0F1E_2D3C, 1'b1, t2);
    wait_idle;
    chk("t3_nrise", 64'(n_rise), 64'(64));
    chk("t3_rx1", 64'(rx_data), 64'h0000_0000_0F1E_2D3C);
    chk("t3_mosi", mosi_log, {32'hCAFE_F00D, 32'h0F1E_2D3C});
    chk("t3_cs_rises", 64'(n_cs_rise), 64'(1));

    // Fastest divider, direct loopback.
    clk_div = 8'd0; miso_mode = 1; clr_mon;
    xfer(32'h3C96_E1A7, 1'b1, t);
    wait_idle;
    chk("t4_rise0", 64'(rise_cyc[0]), 64'(t + 2));
    chk("t4_period", 64'(rise_cyc[1] - rise_cyc[0]), 64'(2));
    chk("t4_rx_cyc", 64'(rx_cyc), 64'(t + 65));
    chk("t4_rx", 64'(rx_data), 64'h0000_0000_3C96_E1A7);

    // Divider changed mid-frame only takes effect on the next frame.
    clk_div = 8'd1; miso_mode = 0; clr_mon;
    xfer(32'h0000_FFFF, 1'b0, t);
    clk_div = 8'd7;
    xfer(32'h9ABC_DEF0, 1'b1, t2);
    wait_idle;
    chk("t5_w2_rise0", 64'(rise_cyc[32]), 64'(t2 + 3));
    chk("t5_w2_period", 64'(rise_cyc[33] - rise_cyc[32]), 64'(4));
    chk("t5_rx", 64'(rx_data), 64'h0000_0000_9ABC_DEF0);
    clr_mon;
    xfer(32'h5555_AAAA, 1'b1, t);
    wait_idle;
    chk("t5_new_rise0", 64'(rise_cyc[0]), 64'(t + 9));
    chk("t5_new_period", 64'(rise_cyc[1] - rise_cyc[0]), 64'(16));

    // Slowest divider with a MISO pattern driven on SCK falls.
    clk_div = 8'd255; miso_mode = 2; pat = 32'h8000_0001; clr_mon;
    xfer(32'h6B6B_0000, 1'b1, t);
    wait_idle;
    chk("t6_rise0", 64'(rise_cyc[0]), 64'(t + 257));
    chk("t6_period", 64'(rise_cyc[1] - rise_cyc[0]), 64'(512));
    chk("t6_rx", 64'(rx_data), 64'h0000_0000_8000_0001);
    chk("t6_nrx", 64'(n_rx), 64'(1));

    // Asynchronous reset in the middle of a word.
    clk_div = 8'd1; miso_mode = 0; clr_mon;
    xfer(32'h1357_9BDF, 1'b1, t);
    for (int i = 0; i < 2000 && n_rise < 10; i++) tick;
    chk("t7_reach_bit10", 64'(n_rise), 64'(10));
    #2 rst_n = 1'b0;
    #1;
    chk("t7_cs", 64'(cs), 64'(1));
    chk("t7_sck", 64'(sck), 64'(0));
    chk("t7_busy", 64'(busy), 64'(0));
    chk("t7_ready", 64'(tx_ready), 64'(0));
    repeat (3) tick;
    chk("t7_no_rxv", 64'(n_rx), 64'(0));
    chk("t7_rxd_clr", 64'(rx_data), 64'(0));
    rst_n = 1'b1;
    tick; tick;
    clr_mon;
    xfer(32'h2468_ACE0, 1'b1, t);
    wait_idle;
    chk("t7_nrx", 64'(n_rx), 64'(1));
    chk("t7_rx", 64'(rx_data), 64'h0000_0000_2468_ACE0);
    chk("t7_nrise", 64'(n_rise), 64'(32));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
